// File: rtl/mp_addsub_if.sv
// Start/done operand and result bundle for mp_addsub.
// The oOvf signal is present only when MP_ADDSUB_OVF_EN is defined.
interface mp_addsub_if #(
  parameter int OPERAND_WIDTH = 128
);
  logic                     iStart;
  logic                     iSub;
  logic [OPERAND_WIDTH-1:0] iOpA;
  logic [OPERAND_WIDTH-1:0] iOpB;
  logic [OPERAND_WIDTH:0]   oRes;
  logic                     oBusy;
  logic                     oDone;
`ifdef MP_ADDSUB_OVF_EN
  logic                     oOvf;

  modport master (output iStart, iSub, iOpA, iOpB, input oRes, oBusy, oDone, oOvf);
  modport slave  (input iStart, iSub, iOpA, iOpB, output oRes, oBusy, oDone, oOvf);
`else
  modport master (output iStart, iSub, iOpA, iOpB, input oRes, oBusy, oDone);
  modport slave  (input iStart, iSub, iOpA, iOpB, output oRes, oBusy, oDone);
`endif
endinterface

// File: rtl/mp_addsub.sv
// Multi-precision add/subtract, one ADDER_WIDTH slice per clock, start/done handshake.
// Define MP_ADDSUB_OVF_EN to add the signed-overflow flag oOvf.
//
// state | meaning
// IDLE  | waiting for iStart
// RUN   | adding one slice per cycle, oBusy high
// DONE  | oDone pulse; iStart here starts the next operation
module mp_addsub #(
  parameter int OPERAND_WIDTH = 128,
  parameter int ADDER_WIDTH   = 32
) (
  input  logic        iClk,
  input  logic        iRstn,
  mp_addsub_if.slave  bus
);
  localparam int NSLICES = OPERAND_WIDTH / ADDER_WIDTH;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                    state, stateNext;
  logic                     startOk;
  logic                     lastSlice;
  logic [CNT_W-1:0]         sliceCnt;
  logic [OPERAND_WIDTH-1:0] rA, rB;
  logic                     rCarry, rSub;
  logic [ADDER_WIDTH:0]     sliceSum;
  logic [OPERAND_WIDTH-1:0] sumNext;
  logic [OPERAND_WIDTH:0]   resReg;

  always_ff @(posedge iClk) begin
    if (!iRstn) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    startOk   = 1'b0;
    lastSlice = 1'b0;
    unique case (state)
      IDLE: if (bus.iStart) begin
        stateNext = RUN;
        startOk   = 1'b1;
      end
      RUN: if (sliceCnt == LAST_SLICE) begin
        stateNext = DONE;
        lastSlice = 1'b1;
      end
      DONE: begin
        startOk   = bus.iStart;
        stateNext = bus.iStart ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign sliceSum = {1'b0, rA[ADDER_WIDTH-1:0]} + {1'b0, rB[ADDER_WIDTH-1:0]}
                  + {{ADDER_WIDTH{1'b0}}, rCarry};

  // Slices enter from the top, so after NSLICES steps the lowest slice sits at bit 0.
  generate
    if (NSLICES == 1) begin : gOneSlice
      assign sumNext = sliceSum[ADDER_WIDTH-1:0];
    end else begin : gMultiSlice
      logic [OPERAND_WIDTH-ADDER_WIDTH-1:0] rAcc;
      assign sumNext = {sliceSum[ADDER_WIDTH-1:0], rAcc};
      always_ff @(posedge iClk) begin
        if (!iRstn)              rAcc <= '0;
        else if (state == RUN)   rAcc <= sumNext[OPERAND_WIDTH-1:ADDER_WIDTH];
      end
    end
  endgenerate

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      rA       <= '0;
      rB       <= '0;
      rCarry   <= 1'b0;
      rSub     <= 1'b0;
      sliceCnt <= '0;
      resReg   <= '0;
    end else if (startOk) begin
      rA       <= bus.iOpA;
      rB       <= bus.iSub ? ~bus.iOpB : bus.iOpB;
      rCarry   <= bus.iSub;
      rSub     <= bus.iSub;
      sliceCnt <= '0;
    end else if (state == RUN) begin
      rA       <= rA >> ADDER_WIDTH;
      rB       <= rB >> ADDER_WIDTH;
      rCarry   <= sliceSum[ADDER_WIDTH];
      sliceCnt <= sliceCnt + 1'b1;
      // In subtract mode the inverted carry-out is the borrow.
      if (lastSlice) resReg <= {rSub ^ sliceSum[ADDER_WIDTH], sumNext};
    end
  end

`ifdef MP_ADDSUB_OVF_EN
  logic carryIntoMsb;
  logic ovfReg;

  assign carryIntoMsb = sliceSum[ADDER_WIDTH-1] ^ rA[ADDER_WIDTH-1] ^ rB[ADDER_WIDTH-1];

  always_ff @(posedge iClk) begin
    if (!iRstn)         ovfReg <= 1'b0;
    else if (lastSlice) ovfReg <= carryIntoMsb ^ sliceSum[ADDER_WIDTH];
  end

  assign bus.oOvf = ovfReg;
`endif

  assign bus.oRes  = resReg;
  assign bus.oBusy = (state == RUN);
  assign bus.oDone = (state == DONE);
endmodule

// File: tb/tb_mp_addsub.sv
// Directed-vector bench for mp_addsub (128-bit operands, 32-bit slices).
module tb_mp_addsub;
  localparam int OW = 128;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mp_addsub_if #(.OPERAND_WIDTH(OW)) bus ();

  mp_addsub #(.OPERAND_WIDTH(OW), .ADDER_WIDTH(32)) dut (
    .iClk (clk),
    .iRstn(rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic          sub;
    logic [OW:0]   res;
    logic          ovf;
  } vecT;

  localparam int NVEC = 10;
  vecT vecs[NVEC];

  task automatic check(input string name, input logic [OW:0] act, input logic [OW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and watch 10 cycles; j counts negedges after the start edge.
  task automatic runOp(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic sub,
                       output int doneAt, output int doneCnt, output int busyCnt,
                       output logic [OW:0] resAtDone);
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iOpA   = a;
    bus.iOpB   = b;
    bus.iSub   = sub;
    @(posedge clk);
    doneAt    = -1;
    doneCnt   = 0;
    busyCnt   = 0;
    resAtDone = '0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) begin
        bus.iStart = 1'b0;
        bus.iOpA   = '0;
        bus.iOpB   = '0;
        bus.iSub   = 1'b0;
      end
      if (bus.oBusy) busyCnt++;
      if (bus.oDone) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt    = j;
          resAtDone = bus.oRes;
        end
      end
    end
  endtask

  int          doneAt, doneCnt, busyCnt, done2At;
  logic [OW:0] resAtDone, res2;
  logic        busyAt5;

  initial begin
    vecs[0] = '{{OW{1'b1}}, 128'h1, 1'b0, {1'b1, 128'h0}, 1'b0};
    vecs[1] = '{128'h0, 128'h1, 1'b1, {(OW+1){1'b1}}, 1'b0};
    vecs[2] = '{128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
                1'b1, 129'h0, 1'b0};
    vecs[3] = '{128'h5, 128'h3, 1'b1, 129'h2, 1'b0};
    vecs[4] = '{{1'b0, {(OW-1){1'b1}}}, 128'h1, 1'b0, {2'b01, 127'h0}, 1'b1};
    vecs[5] = '{{1'b1, 127'h0}, 128'h1, 1'b1, {2'b00, {(OW-1){1'b1}}}, 1'b1};
    vecs[6] = '{128'h3, 128'h5, 1'b1, {{OW{1'b1}}, 1'b0}, 1'b0};
    vecs[7] = '{128'hFFFFFFFF, 128'h1, 1'b0, 129'h1_0000_0000, 1'b0};
    vecs[8] = '{128'h00000001_00000000_00000000_00000000, 128'h1, 1'b1,
                129'h0_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0};
    vecs[9] = '{{1'b1, 127'h0}, {1'b1, 127'h0}, 1'b0, {1'b1, 128'h0}, 1'b1};

    bus.iStart = 1'b0;
    bus.iSub   = 1'b0;
    bus.iOpA   = '0;
    bus.iOpB   = '0;

    // Reset with iStart asserted: reset must win.
    bus.iStart = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset oRes", bus.oRes, '0);
    check("reset oBusy", {128'h0, bus.oBusy}, '0);
    check("reset oDone", {128'h0, bus.oDone}, '0);
`ifdef MP_ADDSUB_OVF_EN
    check("reset oOvf", {128'h0, bus.oOvf}, '0);
`endif
    bus.iStart = 1'b0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after reset oBusy", {128'h0, bus.oBusy}, '0);

    for (int v = 0; v < NVEC; v++) begin
      runOp(vecs[v].a, vecs[v].b, vecs[v].sub, doneAt, doneCnt, busyCnt, resAtDone);
      check($sformatf("vec%0d result", v), resAtDone, vecs[v].res);
      check($sformatf("vec%0d done latency", v), OW'(doneAt), 4);
      check($sformatf("vec%0d done count", v), OW'(doneCnt), 1);
      check($sformatf("vec%0d busy cycles", v), OW'(busyCnt), 4);
      check($sformatf("vec%0d result hold", v), bus.oRes, vecs[v].res);
`ifdef MP_ADDSUB_OVF_EN
      check($sformatf("vec%0d ovf", v), {128'h0, bus.oOvf}, {128'h0, vecs[v].ovf});
`endif
    end

    // iStart during RUN is ignored.
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOpA = 128'h1; bus.iOpB = 128'h2; bus.iSub = 1'b0;
    @(posedge clk);
    doneCnt = 0; doneAt = -1; resAtDone = '0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 0) bus.iStart = 1'b0;
      if (j == 1) begin
        bus.iStart = 1'b1; bus.iOpA = 128'h7; bus.iOpB = 128'h7;
      end
      if (j == 2) bus.iStart = 1'b0;
      if (bus.oDone) begin
        doneCnt++;
        if (doneAt < 0) begin doneAt = j; resAtDone = bus.oRes; end
      end
    end
    check("busy start done count", OW'(doneCnt), 1);
    check("busy start latency", OW'(doneAt), 4);
    check("busy start result", resAtDone, 129'h3);
    check("busy start hold", bus.oRes, 129'h3);

    // Back-to-back: iStart held through DONE starts 6+9 with no idle gap.
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOpA = 128'd10; bus.iOpB = 128'd20; bus.iSub = 1'b0;
    @(posedge clk);
    doneAt = -1; done2At = -1; doneCnt = 0; resAtDone = '0; res2 = '0; busyAt5 = 1'b0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 0) begin bus.iOpA = 128'd6; bus.iOpB = 128'd9; end
      if (j == 5) begin
        busyAt5 = bus.oBusy;
        bus.iStart = 1'b0;
      end
      if (bus.oDone) begin
        doneCnt++;
        if (doneAt < 0) begin doneAt = j; resAtDone = bus.oRes; end
        else if (done2At < 0) begin done2At = j; res2 = bus.oRes; end
      end
    end
    check("b2b first latency", OW'(doneAt), 4);
    check("b2b first result", resAtDone, 129'd30);
    check("b2b busy on restart", {128'h0, busyAt5}, 129'h1);
    check("b2b second gap", OW'(done2At - doneAt), 5);
    check("b2b second result", res2, 129'd15);
    check("b2b done count", OW'(doneCnt), 2);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOpA = {OW{1'b1}}; bus.iOpB = 128'h1; bus.iSub = 1'b0;
    @(posedge clk);
    doneCnt = 0; busyCnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) bus.iStart = 1'b0;
      if (j == 1) rstn = 1'b0;
      if (j == 2) rstn = 1'b1;
      if (j >= 2 && bus.oBusy) busyCnt++;
      if (bus.oDone) doneCnt++;
    end
    check("abort done count", OW'(doneCnt), 0);
    check("abort oRes", bus.oRes, '0);
    check("abort busy after reset", OW'(busyCnt), 0);

    // Unit must still work after an aborted operation.
    runOp(128'd100, 128'd58, 1'b1, doneAt, doneCnt, busyCnt, resAtDone);
    check("post-abort result", resAtDone, 129'd42);
    check("post-abort latency", OW'(doneAt), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
